lab3_enc8_arb: RTL and testbench

LAB3_ENC8_ARB -- requirements
Module: lab3_enc8_arb

---
 rtl/lab3_pkg.sv | 24 ++
 rtl/lab3_prio_enc.sv | 21 ++
 rtl/lab3_enc8_arb.sv | 93 +++++++++
 tb/tb_lab3_enc8_arb.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lab3_pkg.sv
// Shared sizing, FSM states and priority helper
// for the 8-line request encoder/arbiter.
package lab3_pkg;

  localparam int N = 8;
  localparam int W = $clog2(N);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } arb_state_e;

  function automatic logic [W-1:0] hi_index(
    input logic [N-1:0] vec
  );
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lab3_prio_enc.sv
// Combinational N-to-W encoder;
// the highest set index wins.
module lab3_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] code,
  output logic         any
);

  always_comb begin
    code = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) code = W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/lab3_enc8_arb.sv
// Pending-request register with fixed-priority
// grant presented over a valid/ready handshake.
module lab3_enc8_arb
  import lab3_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  input  logic         ready_in,
  output logic [W-1:0] code_out,
  output logic         valid_out,
  output logic [N-1:0] pend_out,
  output logic [W:0]   cnt_out,
  output logic         multi_out
);

  arb_state_e   state_q, state_d;
  logic [N-1:0] pend_q, pend_d, clr;
  logic [W-1:0] code_q, code_d, hi_code;
  logic         hi_any, accept;

  assign valid_out = (state_q == ST_PRESENT);
  assign accept    = valid_out & ready_in;

  // A request arriving with its own accept re-sets the bit
  assign clr    = accept ? ({{(N-1){1'b0}}, 1'b1} << code_q) : '0;
  assign pend_d = (pend_q & ~clr) | req_in;

  lab3_prio_enc #(
    .N(N),
    .W(W)
  ) u_prio (
    .vec (pend_d),
    .code(hi_code),
    .any (hi_any)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hi_any) begin
          state_d = ST_PRESENT;
          code_d  = hi_code;
        end else begin
          code_d  = '0;
        end
      end
      ST_PRESENT: begin
        if (accept) begin
          if (hi_any) begin
            code_d  = hi_code;
          end else begin
            state_d = ST_IDLE;
            code_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < N; i++) begin
      cnt_out = cnt_out + (W+1)'(pend_q[i]);
    end
  end

  assign multi_out = (cnt_out > (W+1)'(1));
  assign code_out  = code_q;
  assign pend_out  = pend_q;

endmodule

// File: tb/tb_lab3_enc8_arb.sv
// Directed bench for lab3_enc8_arb with
// hand-computed expectations.
module tb_lab3_enc8_arb;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic       ready_in;
  logic [2:0] code_out;
  logic       valid_out;
  logic [7:0] pend_out;
  logic [3:0] cnt_out;
  logic       multi_out;

  int total;
  int bad;

  lab3_enc8_arb #(
    .N(8),
    .W(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .ready_in (ready_in),
    .code_out (code_out),
    .valid_out(valid_out),
    .pend_out (pend_out),
    .cnt_out  (cnt_out),
    .multi_out(multi_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_code"},  32'(code_out),  32'd0);
    chk({tag, "_pend"},  32'(pend_out),  32'd0);
    chk({tag, "_cnt"},   32'(cnt_out),   32'd0);
    chk({tag, "_multi"}, 32'(multi_out), 32'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    req_in   = '0;
    ready_in = 1'b0;

    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;

    // sweep
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_in = 8'(1 << i);
      step();
      chk($sformatf("sweep%0d_code", i), 32'(code_out), 32'(i));
      chk($sformatf("sweep%0d_valid", i), 32'(valid_out), 32'd1);
      chk($sformatf("sweep%0d_cnt", i), 32'(cnt_out), 32'd1);
    end
    req_in = '0;
    step();
    chk_zero("sweep_end");

    // burst
    req_in = 8'b1010_0110;
    step();
    req_in = '0;
    chk("burst0_code",  32'(code_out),  32'd7);
    chk("burst0_cnt",   32'(cnt_out),   32'd4);
    chk("burst0_multi", 32'(multi_out), 32'd1);
    step();
    chk("burst1_code", 32'(code_out), 32'd5);
    chk("burst1_cnt",  32'(cnt_out),  32'd3);
    step();
    chk("burst2_code", 32'(code_out), 32'd2);
    chk("burst2_cnt",  32'(cnt_out),  32'd2);
    step();
    chk("burst3_code",  32'(code_out),  32'd1);
    chk("burst3_cnt",   32'(cnt_out),   32'd1);
    chk("burst3_multi", 32'(multi_out), 32'd0);
    chk("burst3_valid", 32'(valid_out), 32'd1);
    step();
    chk_zero("burst_end");

    // backpressure
    ready_in = 1'b0;
    req_in   = 8'h01;
    step();
    chk("bp0_code",  32'(code_out),  32'd0);
    chk("bp0_valid", 32'(valid_out), 32'd1);
    req_in = 8'h80;
    step();
    chk("bp1_code",  32'(code_out),  32'd0);
    chk("bp1_valid", 32'(valid_out), 32'd1);
    chk("bp1_pend",  32'(pend_out),  32'h81);
    req_in = '0;
    step();
    chk("bp2_code", 32'(code_out), 32'd0);
    ready_in = 1'b1;
    step();
    chk("bp3_code",  32'(code_out),  32'd7);
    chk("bp3_pend",  32'(pend_out),  32'h80);
    chk("bp3_valid", 32'(valid_out), 32'd1);
    step();
    chk_zero("bp_end");

    // simultaneous accept and re-request
    ready_in = 1'b0;
    req_in   = 8'h08;
    step();
    chk("sim0_code", 32'(code_out), 32'd3);
    ready_in = 1'b1;
    req_in   = 8'h08;
    step();
    chk("sim1_pend",  32'(pend_out),  32'h08);
    chk("sim1_code",  32'(code_out),  32'd3);
    chk("sim1_valid", 32'(valid_out), 32'd1);
    req_in = '0;
    step();
    chk_zero("sim_end");

    // asynchronous reset mid-PRESENT
    ready_in = 1'b0;
    req_in   = 8'hFF;
    step();
    chk("rst0_pend",  32'(pend_out),  32'hFF);
    chk("rst0_code",  32'(code_out),  32'd7);
    chk("rst0_cnt",   32'(cnt_out),   32'd8);
    chk("rst0_multi", 32'(multi_out), 32'd1);
    req_in = '0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    #1;
    rst_n = 1'b1;
    step();
    chk_zero("rst_release");

    // idle with ready high
    ready_in = 1'b1;
    req_in   = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle%0d_valid", i), 32'(valid_out), 32'd0);
      chk($sformatf("idle%0d_code", i),  32'(code_out),  32'd0);
      chk($sformatf("idle%0d_cnt", i),   32'(cnt_out),   32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
